pipe_sequencer: RTL

- Control block for the 3-stage fetch / execute / writeback core.
- Owns the fetch PC and the per-stage valid bits. Applies branch/jump redirects from the EX stage and squashes the wrong-path instruction.
- Sequences run, halt and single-step modes for board-level debug from switches/keys.
- The datapath gates register-file writes and display writes with the valid bits this block produces.

---
 rtl/pipe_sequencer_if.sv | 41 ++++
 rtl/pipe_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipe_sequencer_if.sv
// ---------------------------------------------------------------------------
// pipe_sequencer_if
// Bundle between the pipeline sequencer and the fetch/execute/writeback
// datapath (plus the debug switches/keys that drive run and step).
//
// Signals:
//   run_en       master->slave  level, 1 = free-run, 0 = request halt
//   step_req     master->slave  key level, rising edge in HALT = one step
//   redirect_ex  master->slave  taken branch/jump resolved in EX
//   target_ex    master->slave  redirect word address
//   pc_f         slave->master  instruction-memory address this cycle
//   fetch_en     slave->master  datapath captures inst_ram[pc_f] into EX
//   ex_valid     slave->master  EX-stage instruction is real
//   wb_valid     slave->master  WB-stage instruction is real
//   halted       slave->master  sequencer is parked in HALT
//   retired_cnt  slave->master  instructions retired from WB
// ---------------------------------------------------------------------------
interface pipe_sequencer_if #(
    parameter int PC_W = 12
);
    logic            run_en;
    logic            step_req;
    logic            redirect_ex;
    logic [PC_W-1:0] target_ex;
    logic [PC_W-1:0] pc_f;
    logic            fetch_en;
    logic            ex_valid;
    logic            wb_valid;
    logic            halted;
    logic [31:0]     retired_cnt;

    modport master (
        output run_en, step_req, redirect_ex, target_ex,
        input  pc_f, fetch_en, ex_valid, wb_valid, halted, retired_cnt
    );

    modport slave (
        input  run_en, step_req, redirect_ex, target_ex,
        output pc_f, fetch_en, ex_valid, wb_valid, halted, retired_cnt
    );
endinterface

// File: rtl/pipe_sequencer.sv
// ---------------------------------------------------------------------------
// pipe_sequencer
// Control block for the 3-stage fetch/execute/writeback core. Owns the fetch
// PC and the per-stage valid bits, applies EX-stage redirects (squashing the
// wrong-path fetch) and sequences run / halt / single-step for board debug.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous, active-low reset
//   sq     pipe_sequencer_if.slave (run_en, step_req, redirect_ex, target_ex
//          in; pc_f, fetch_en, ex_valid, wb_valid, halted, retired_cnt out)
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | parked, no fetch; waits for run_en or a step_req rising edge
// RUN   | fetch every cycle until run_en drops
// STEP  | single fetch cycle triggered from HALT
// DRAIN | one cycle with no fetch so the last fetch reaches EX/WB cleanly
// ---------------------------------------------------------------------------
module pipe_sequencer #(
    parameter int PC_W      = 12,
    parameter int MEM_DEPTH = 4096,
    parameter int RESET_PC  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_sequencer_if.slave sq
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] LP_LAST  = PC_W'(MEM_DEPTH - 1);
    localparam logic [PC_W-1:0] LP_RESET = PC_W'(RESET_PC);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_ex_valid;
    logic            r_wb_valid;
    logic            r_halted;
    logic            r_step_d;
    logic [31:0]     r_retired;

    logic            w_redir;
    logic            w_step_rise;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_fetch_next;

    // A redirect only means something when the instruction that raised it
    // is real; a bubble in EX cannot branch.
    assign w_redir     = sq.redirect_ex & r_ex_valid;
    assign w_step_rise = sq.step_req & ~r_step_d;

    // Targets beyond the memory are folded back into it.
    assign w_target = PC_W'(32'(sq.target_ex) % 32'(MEM_DEPTH));
    assign w_pc_inc = (r_pc == LP_LAST) ? LP_RESET : r_pc + PC_W'(1);
    assign w_pc_fetch_next = w_redir ? w_target : w_pc_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_HALT;
            r_pc       <= LP_RESET;
            r_ex_valid <= 1'b0;
            r_wb_valid <= 1'b0;
            r_halted   <= 1'b1;
            // Cleared high so a key already held through reset is not
            // mistaken for a fresh press.
            r_step_d   <= 1'b1;
            r_retired  <= 32'd0;
        end else begin
            r_step_d   <= sq.step_req;
            r_wb_valid <= r_ex_valid;
            r_retired  <= r_retired + 32'(r_wb_valid);

            case (r_state)
                S_HALT: begin
                    r_ex_valid <= 1'b0;
                    if (sq.run_en) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end else if (w_step_rise) begin
                        r_state  <= S_STEP;
                        r_halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The sequential fetch on a redirect edge is wrong-path
                    // and enters EX as a bubble.
                    r_pc       <= w_pc_fetch_next;
                    r_ex_valid <= ~w_redir;
                    if (!sq.run_en) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_STEP: begin
                    r_pc       <= w_pc_fetch_next;
                    r_ex_valid <= ~w_redir;
                    r_state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_ex_valid <= 1'b0;
                    if (w_redir) begin
                        r_pc <= w_target;
                    end
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_ex_valid <= 1'b0;
                    r_state    <= S_HALT;
                    r_halted   <= 1'b1;
                end
            endcase
        end
    end

    // Pure decode of the state register: no input reaches fetch_en
    // combinationally.
    assign sq.fetch_en    = (r_state == S_RUN) || (r_state == S_STEP);
    assign sq.pc_f        = r_pc;
    assign sq.ex_valid    = r_ex_valid;
    assign sq.wb_valid    = r_wb_valid;
    assign sq.halted      = r_halted;
    assign sq.retired_cnt = r_retired;

endmodule
